display_7seg_param: RTL and testbench

- Parametrised successor of the 8-digit 7-segment multiplexed display driver.
- Accepts a signed or unsigned binary word from the Booth multiplier datapath on a load strobe.
- Converts the word to BCD internally with a sequential shift-add-3 (double dabble) engine, so upstream no longer supplies BCD.
- Scans the digits with a programmable refresh rate, leading-zero blanking, minus-sign placement and overflow indication.

---
 rtl/display_7seg_param.sv | 221 ++++++++++++++++++++++
 tb/tb_display_7seg_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_7seg_param.sv
// Multiplexed 7-segment driver: binary word in, sequential double-dabble to BCD,
// formatted (blanking, minus sign, overflow) into per-digit segment registers and scanned out.
module display_7seg_param #(
    parameter int N_DIGITS    = 8,
    parameter int DATA_W      = 21,
    parameter int SIGNED      = 1,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   valor,
    input  logic                load,
    input  logic                blank_en,
    output logic                busy,
    output logic                overflow,
    output logic [N_DIGITS-1:0] anodo,
    output logic [6:0]          catodo,
    output logic [1:0]          dbg_state
);

    localparam int BCD_W = 4 * (N_DIGITS + 1);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int K_W   = $clog2(N_DIGITS + 1);
    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]          mag_q, mag_d;
    logic [BCD_W-1:0]           bcd_q, bcd_d;
    logic                       carry_q, carry_d;
    logic                       neg_q, neg_d;
    logic                       blank_q, blank_d;
    logic                       busy_q, busy_d;
    logic                       ovf_q, ovf_d;
    logic [N_DIGITS-1:0][6:0]   segs_q, segs_d;

    logic [PRE_W-1:0]           presc_q, presc_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [N_DIGITS-1:0]        anodo_q, anodo_d;
    logic [6:0]                 catodo_q, catodo_d;

    logic                       neg_in;
    logic [DATA_W-1:0]          mag_in;
    logic [BCD_W-1:0]           bcd_adj;
    logic [K_W-1:0]             k;
    logic                       fmt_ovf;
    logic [N_DIGITS-1:0][6:0]   fmt_segs;

    // DATA_W bits read as unsigned already hold 2^(DATA_W-1), so the most negative input negates cleanly.
    assign neg_in = (SIGNED != 0) && valor[DATA_W-1];
    assign mag_in = neg_in ? (~valor + DATA_W'(1)) : valor;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i <= N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // A bit leaving the top nibble means the value needs more than N_DIGITS+1 digits.
    always_comb begin
        k = '0;
        for (int i = 0; i <= N_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) begin
                k = K_W'(i);
            end
        end
        fmt_ovf = carry_q
               || (bcd_q[4*N_DIGITS +: 4] != 4'd0)
               || (neg_q && (k == K_W'(N_DIGITS - 1)))
               || (neg_q && !blank_q && (bcd_q[4*(N_DIGITS-1) +: 4] != 4'd0));
        fmt_segs = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (fmt_ovf) begin
                fmt_segs[i] = SEG_MINUS;
            end else if (blank_q && (K_W'(i) > k)) begin
                fmt_segs[i] = (neg_q && (K_W'(i) == k + K_W'(1))) ? SEG_MINUS : SEG_BLANK;
            end else if (!blank_q && neg_q && (i == N_DIGITS - 1)) begin
                fmt_segs[i] = SEG_MINUS;
            end else begin
                fmt_segs[i] = seg7(bcd_q[4*i +: 4]);
            end
        end
    end

    // load is a one-cycle request, taken only in IDLE; while busy=1 it is dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        blank_d = blank_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        segs_d  = segs_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    mag_d   = mag_in;
                    neg_d   = neg_in;
                    blank_d = blank_en;
                    bcd_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                bcd_d   = {bcd_adj[BCD_W-2:0], mag_q[DATA_W-1]};
                carry_d = carry_q | bcd_adj[BCD_W-1];
                mag_d   = mag_q << 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                segs_d  = fmt_segs;
                ovf_d   = fmt_ovf;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            blank_q <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_DIGITS; i++) begin
                segs_q[i] <= (i == 0) ? SEG_ZERO : SEG_BLANK;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            segs_q  <= segs_d;
        end
    end

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_W'(REFRESH_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        anodo_d  = ~(N_DIGITS'(1) << idx_q);
        catodo_d = segs_q[idx_q];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= '0;
            idx_q    <= '0;
            anodo_q  <= '1;
            catodo_q <= SEG_BLANK;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            anodo_q  <= anodo_d;
            catodo_q <= catodo_d;
        end
    end

    assign busy      = busy_q;
    assign overflow  = ovf_q;
    assign anodo     = anodo_q;
    assign catodo    = catodo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_display_7seg_param.sv
// Bench for display_7seg_param: an 8-digit and a 4-digit instance share stimulus;
// expected displays come from a decimal-arithmetic model and are checked by a monitor on each commit.
module tb_display_7seg_param;

    localparam int DW = 21;
    localparam int RD = 4;
    localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    localparam logic [6:0] MINUS = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] valor = '0;
    logic          load = 1'b0;
    logic          blank_en = 1'b0;

    logic          busy_a, ovf_a, busy_b, ovf_b;
    logic [7:0]    anodo_a;
    logic [3:0]    anodo_b;
    logic [6:0]    catodo_a, catodo_b;
    logic [1:0]    dbg_a, dbg_b;

    int checks = 0;
    int failures = 0;
    int commits = 0;
    int n_exp = 0;

    logic [56:0] exp_a_q [$];
    logic [28:0] exp_b_q [$];

    display_7seg_param #(.N_DIGITS(8), .DATA_W(DW), .SIGNED(1), .REFRESH_DIV(RD)) dut_a (
        .clk(clk), .reset(reset), .valor(valor), .load(load), .blank_en(blank_en),
        .busy(busy_a), .overflow(ovf_a), .anodo(anodo_a), .catodo(catodo_a), .dbg_state(dbg_a)
    );

    display_7seg_param #(.N_DIGITS(4), .DATA_W(DW), .SIGNED(1), .REFRESH_DIV(RD)) dut_b (
        .clk(clk), .reset(reset), .valor(valor), .load(load), .blank_en(blank_en),
        .busy(busy_b), .overflow(ovf_b), .anodo(anodo_b), .catodo(catodo_b), .dbg_state(dbg_b)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: decimal digits of |v| by repeated division, then the display rules on n digits.
    // Returns {overflow, seg[7..0]}; digits at or above n read as blank.
    function automatic logic [56:0] model(input int v, input int n, input bit bl);
        int  m, nd;
        int  dig [10];
        bit  neg, ovf;
        logic [56:0] r;
        logic [6:0]  s;
        neg = (v < 0);
        m = neg ? -v : v;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            dig[i] = m % 10;
            m = m / 10;
            if (dig[i] != 0) nd = i + 1;
        end
        if (nd == 0) nd = 1;
        ovf = (nd > n) || (neg && nd >= n);
        r = '1;
        r[56] = ovf;
        for (int i = 0; i < 8; i++) begin
            if (i >= n)          s = BLANK;
            else if (ovf)        s = MINUS;
            else if (i < nd)     s = SEG_TAB[dig[i]];
            else if (bl)         s = (neg && i == nd) ? MINUS : BLANK;
            else                 s = (neg && i == n - 1) ? MINUS : SEG_TAB[0];
            r[i*7 +: 7] = s;
        end
        return r;
    endfunction

    // Watch one full scan period and record which segments each digit showed.
    task automatic collect(output logic [55:0] seg_a, output logic [27:0] seg_b);
        seg_a = 'x;
        seg_b = 'x;
        for (int c = 0; c < 8 * RD; c++) begin
            @(negedge clk);
            chk("onehot_a", 64'($countones(~anodo_a)), 64'd1);
            chk("onehot_b", 64'($countones(~anodo_b)), 64'd1);
            for (int j = 0; j < 8; j++) if (!anodo_a[j]) seg_a[j*7 +: 7] = catodo_a;
            for (int j = 0; j < 4; j++) if (!anodo_b[j]) seg_b[j*7 +: 7] = catodo_b;
        end
    endtask

    // driver tasks
    task automatic do_load(input int v, input bit bl, input bit push);
        logic [31:0] raw;
        logic [56:0] ra, rb;
        raw = v;
        @(negedge clk);
        valor = raw[DW-1:0];
        blank_en = bl;
        load = 1'b1;
        if (push) begin
            ra = model(v, 8, bl);
            rb = model(v, 4, bl);
            exp_a_q.push_back(ra);
            exp_b_q.push_back({rb[56], rb[27:0]});
            n_exp++;
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_commit();
        int t;
        t = 0;
        while (commits < n_exp && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("commit_timeout", 64'(commits >= n_exp), 64'd1);
    endtask

    // monitor / scoreboard
    initial begin : monitor
        logic prev_busy;
        logic [56:0] ea;
        logic [28:0] eb;
        logic [55:0] ga;
        logic [27:0] gb;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && prev_busy && !busy_a) begin
                chk("busy_b_at_commit", 64'(busy_b), 64'd0);
                if (exp_a_q.size() == 0 || exp_b_q.size() == 0) begin
                    chk("unexpected_commit", 64'(exp_a_q.size()), 64'd1);
                end else begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    chk("overflow_a", 64'(ovf_a), 64'(ea[56]));
                    chk("overflow_b", 64'(ovf_b), 64'(eb[28]));
                    collect(ga, gb);
                    chk("digits_a", 64'(ga), 64'(ea[55:0]));
                    chk("digits_b", 64'(gb), 64'(eb[27:0]));
                end
                commits++;
            end
            prev_busy = busy_a;
        end
    end

    // stimulus
    initial begin : driver
        logic [56:0] r0a, r0b;
        logic [55:0] ga;
        logic [27:0] gb;
        logic [7:0]  ea8;
        logic [3:0]  eb4;
        int          cnt, nd, m, v;
        int          dir_tab [8] = '{0, 1, 9999, -1000, 1048575, -1, 10000, -1048576};

        repeat (3) @(negedge clk);
        chk("rst_anodo_a", 64'(anodo_a), 64'hFF);
        chk("rst_anodo_b", 64'(anodo_b), 64'hF);
        chk("rst_catodo_a", 64'(catodo_a), 64'h7F);
        chk("rst_busy_a", 64'(busy_a), 64'd0);
        chk("rst_ovf_a", 64'(ovf_a), 64'd0);
        #1 reset = 1'b1;

        // Free-running scan after reset: "0" on digit 0, others blank, 4 clocks per digit.
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            ea8 = 8'hFF;
            ea8[(i / RD) % 8] = 1'b0;
            eb4 = 4'hF;
            eb4[(i / RD) % 4] = 1'b0;
            chk("scan_anodo_a", 64'(anodo_a), 64'(ea8));
            chk("scan_anodo_b", 64'(anodo_b), 64'(eb4));
            chk("scan_catodo_a", 64'(catodo_a), 64'((((i / RD) % 8) == 0) ? SEG_TAB[0] : BLANK));
            chk("scan_busy_a", 64'(busy_a), 64'd0);
        end

        // Busy window length on a plain load.
        do_load(1234, 1'b1, 1'b1);
        cnt = 0;
        while (busy_a && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        chk("busy_len", 64'(cnt), 64'd22);
        wait_commit();

        do_load(-1048576, 1'b1, 1'b1); wait_commit();
        do_load(-5, 1'b0, 1'b1);       wait_commit();
        do_load(12345, 1'b1, 1'b1);    wait_commit();
        do_load(-999, 1'b1, 1'b1);     wait_commit();
        for (int i = 0; i < 8; i++) begin
            do_load(dir_tab[i], i[0], 1'b1);
            wait_commit();
        end

        // A second load while busy must be dropped.
        do_load(777, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        do_load(-4321, 1'b0, 1'b0);
        wait_commit();
        repeat (5) @(negedge clk);
        chk("ignored_load_busy", 64'(busy_a), 64'd0);

        for (int i = 0; i < 40; i++) begin
            nd = $urandom_range(1, 7);
            m = $urandom_range(0, 10 ** nd - 1);
            if (m > 1048575) m = m % 1048576;
            v = ($urandom_range(0, 1) == 1) ? -m : m;
            do_load(v, 1'($urandom_range(0, 1)), 1'b1);
            wait_commit();
        end

        // Reset in the middle of SHIFT: outputs fall back immediately, display returns to "0".
        do_load(-55555, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy_a", 64'(busy_a), 64'd0);
        chk("midrst_busy_b", 64'(busy_b), 64'd0);
        chk("midrst_anodo_a", 64'(anodo_a), 64'hFF);
        chk("midrst_catodo_a", 64'(catodo_a), 64'h7F);
        chk("midrst_ovf_a", 64'(ovf_a), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        collect(ga, gb);
        r0a = model(0, 8, 1'b1);
        r0b = model(0, 4, 1'b1);
        chk("postrst_digits_a", 64'(ga), 64'(r0a[55:0]));
        chk("postrst_digits_b", 64'(gb), 64'(r0b[27:0]));

        do_load(-42, 1'b1, 1'b1);
        wait_commit();

        chk("queue_empty", 64'(exp_a_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
